// File: rtl/wb_arbiter_if.sv
// Bus bundle between eight requesters and the wb_arbiter: requests, locks,
// payloads, stall, and the registered output stream.
interface wb_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [7:0]       iReq;
  logic [7:0]       iLock;
  logic [WIDTH-1:0] iData0;
  logic [WIDTH-1:0] iData1;
  logic [WIDTH-1:0] iData2;
  logic [WIDTH-1:0] iData3;
  logic [WIDTH-1:0] iData4;
  logic [WIDTH-1:0] iData5;
  logic [WIDTH-1:0] iData6;
  logic [WIDTH-1:0] iData7;
  logic             iStall;
  logic [7:0]       oGnt;
  logic [2:0]       oSel;
  logic             oValid;
  logic [WIDTH-1:0] oData;
  logic [2:0]       oSrc;

  modport master (
    output iReq, iLock, iData0, iData1, iData2, iData3,
           iData4, iData5, iData6, iData7, iStall,
    input  oGnt, oSel, oValid, oData, oSrc
  );

  modport slave (
    input  iReq, iLock, iData0, iData1, iData2, iData3,
           iData4, iData5, iData6, iData7, iStall,
    output oGnt, oSel, oValid, oData, oSrc
  );
endinterface

// File: rtl/wb_arbiter.sv
// 8-way round-robin arbiter with bounded lock ownership and a registered
// payload output stage fed by a shared 8:1 mux.
module wb_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MAXHOLD = 4
) (
  input logic         iClk,
  input logic         iRst_n,
  wb_arbiter_if.slave bus
);
  localparam int unsigned HW = $clog2(MAXHOLD + 1);

  typedef enum logic {IDLE, OWN} stateT;

  stateT            state;
  logic [2:0]       owner;
  logic [2:0]       ptr;
  logic [HW-1:0]    holdCnt;
  logic             validReg;
  logic [WIDTH-1:0] dataReg;
  logic [2:0]       srcReg;
  logic [2:0]       selReg;

  logic             gntValid;
  logic             keepOwner;
  logic             ownerHeld;
  logic [2:0]       winner;
  logic [2:0]       sel;
  logic [7:0]       others;
  logic [7:0]       mask;
  logic [WIDTH-1:0] muxData;

  // First set bit of mask at or after start, wrapping modulo 8.
  function automatic logic [2:0] rrPick(input logic [7:0] m, input logic [2:0] start);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && m[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Grant decision: locked owner keeps the bus until its hold budget is spent
  // and someone else is waiting; otherwise plain round-robin.
  always_comb begin
    gntValid  = 1'b0;
    keepOwner = 1'b0;
    winner    = ptr;
    mask      = 8'h00;
    ownerHeld = (state == OWN) && bus.iReq[owner] && bus.iLock[owner];
    others    = bus.iReq & ~(8'h01 << owner);
    if (iRst_n && !bus.iStall) begin
      if (ownerHeld && ((holdCnt < HW'(MAXHOLD)) || (others == 8'h00))) begin
        gntValid  = 1'b1;
        keepOwner = 1'b1;
        winner    = owner;
      end else begin
        mask = ownerHeld ? others : bus.iReq;
        if (|mask) begin
          gntValid = 1'b1;
          winner   = rrPick(mask, ptr);
        end
      end
    end
  end

  assign sel = gntValid ? winner : selReg;

  always_comb begin
    case (sel)
      3'd0:    muxData = bus.iData0;
      3'd1:    muxData = bus.iData1;
      3'd2:    muxData = bus.iData2;
      3'd3:    muxData = bus.iData3;
      3'd4:    muxData = bus.iData4;
      3'd5:    muxData = bus.iData5;
      3'd6:    muxData = bus.iData6;
      default: muxData = bus.iData7;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state    <= IDLE;
      owner    <= 3'd0;
      ptr      <= 3'd0;
      holdCnt  <= '0;
      validReg <= 1'b0;
      dataReg  <= '0;
      srcReg   <= 3'd0;
      selReg   <= 3'd0;
    end else if (bus.iStall) begin
      validReg <= 1'b0;
    end else begin
      validReg <= gntValid;
      if (gntValid) begin
        ptr     <= winner + 3'd1;
        dataReg <= muxData;
        srcReg  <= winner;
        selReg  <= winner;
        if (keepOwner) begin
          if (holdCnt < HW'(MAXHOLD)) holdCnt <= holdCnt + HW'(1);
        end else if (bus.iLock[winner]) begin
          state   <= OWN;
          owner   <= winner;
          holdCnt <= HW'(1);
        end else begin
          state   <= IDLE;
          holdCnt <= '0;
        end
      end else begin
        state   <= IDLE;
        holdCnt <= '0;
      end
    end
  end

  assign bus.oGnt   = gntValid ? (8'h01 << winner) : 8'h00;
  assign bus.oSel   = sel;
  assign bus.oValid = validReg;
  assign bus.oData  = dataReg;
  assign bus.oSrc   = srcReg;
endmodule
